// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI definitions for burst address generation: default widths, burst
// encoding, 4 KB page size and the per-beat address step used by the generator and reference models.
package axi_burst_addr_gen_pkg;

  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 256;
  localparam int AXI_LEN_WIDTH  = 8;

  // Wide enough for any supported ADDR_WIDTH plus carry; callers truncate.
  localparam int CALC_W = 64;

  // 4 KB page: bursts may not cross a boundary of 1 << PAGE_SHIFT bytes.
  localparam int PAGE_SHIFT = 12;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [CALC_W-1:0] next_beat_addr(
    input logic [CALC_W-1:0] addr,
    input logic [2:0]        size,
    input burst_e            burst,
    input logic [CALC_W-1:0] lo,
    input logic [CALC_W-1:0] w
  );
    logic [CALC_W-1:0] step;
    logic [CALC_W-1:0] nxt;
    step = 64'd1 << size;
    nxt  = addr;
    case (burst)
      BURST_INCR: nxt = (addr & ~(step - 64'd1)) + step;
      BURST_WRAP: begin
        nxt = addr + step;
        if (nxt == lo + w) nxt = lo;
      end
      default:    nxt = addr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Expands one AW/AR-style command into per-beat addresses (FIXED/INCR/WRAP),
// rejecting illegal commands with a one-cycle cmd_err pulse.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// BUSY    | presenting beats until the last-beat handshake
module axi_burst_addr_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ID_WIDTH   = AXI_ID_WIDTH,
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int LEN_WIDTH  = AXI_LEN_WIDTH,
  localparam int OFF_W     = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  cmd_err,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [OFF_W-1:0]      beat_offset,
  output logic [LEN_WIDTH-1:0]  beat_idx,
  output logic                  beat_last
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [LEN_WIDTH-1:0]  len_t;
  typedef logic [CALC_W-1:0]     calc_t;

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  addr_t                 addr_q, addr_d;
  len_t                  idx_q, idx_d;
  len_t                  len_q, len_d;
  logic [2:0]            size_q, size_d;
  burst_e                burst_q, burst_d;
  addr_t                 lo_q, lo_d;
  logic [15:0]           w_q, w_d;
  logic                  err_q, err_d;

  burst_e cmd_burst_e;
  calc_t  cmd_addr_w;
  calc_t  cmd_step;
  calc_t  cmd_span;
  calc_t  cmd_last_byte;
  calc_t  cmd_wrap_lo;
  logic   cmd_illegal;
  calc_t  next_addr_w;
  logic   last_beat;

  // Command legality and WRAP window, evaluated on the raw command inputs.
  always_comb begin
    cmd_burst_e   = burst_e'(cmd_burst);
    cmd_addr_w    = calc_t'(cmd_addr);
    cmd_step      = 64'd1 << cmd_size;
    cmd_span      = (calc_t'(cmd_len) + 64'd1) << cmd_size;
    cmd_last_byte = (cmd_addr_w & ~(cmd_step - 64'd1)) + cmd_span - 64'd1;
    cmd_wrap_lo   = cmd_addr_w & ~(cmd_span - 64'd1);
    cmd_illegal   = 1'b0;
    if (cmd_size > MAX_SIZE) cmd_illegal = 1'b1;
    case (cmd_burst_e)
      BURST_FIXED: begin
        if (calc_t'(cmd_len) > 64'd15) cmd_illegal = 1'b1;
      end
      BURST_INCR: begin
        if (cmd_last_byte[CALC_W-1:PAGE_SHIFT] != cmd_addr_w[CALC_W-1:PAGE_SHIFT])
          cmd_illegal = 1'b1;
      end
      BURST_WRAP: begin
        if ((cmd_len != len_t'(1)) && (cmd_len != len_t'(3)) &&
            (cmd_len != len_t'(7)) && (cmd_len != len_t'(15)))
          cmd_illegal = 1'b1;
        if ((cmd_addr_w & (cmd_step - 64'd1)) != 64'd0) cmd_illegal = 1'b1;
      end
      default:     cmd_illegal = 1'b1;
    endcase
  end

  assign next_addr_w = next_beat_addr(calc_t'(addr_q), size_q, burst_q,
                                      calc_t'(lo_q), calc_t'(w_q));
  assign last_beat   = (idx_q == len_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    lo_d    = lo_q;
    w_d     = w_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_illegal) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_BUSY;
            id_d    = cmd_id;
            addr_d  = cmd_addr;
            idx_d   = '0;
            len_d   = cmd_len;
            size_d  = cmd_size;
            burst_d = cmd_burst_e;
            lo_d    = addr_t'(cmd_wrap_lo);
            w_d     = cmd_span[15:0];
          end
        end
      end
      ST_BUSY: begin
        if (beat_ready) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            idx_d  = idx_q + len_t'(1);
            addr_d = addr_t'(next_addr_w);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
      lo_q    <= '0;
      w_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      lo_q    <= lo_d;
      w_q     <= w_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign beat_valid  = (state_q == ST_BUSY);
  assign cmd_err     = err_q;
  assign beat_id     = id_q;
  assign beat_addr   = addr_q;
  assign beat_idx    = idx_q;
  assign beat_last   = (state_q == ST_BUSY) && last_beat;
  assign beat_offset = (DATA_WIDTH > 8) ? addr_q[OFF_W-1:0] : '0;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench: directed bursts from the test plan plus randomized
// commands checked against an arithmetic reference of the burst rules.
module tb_axi_burst_addr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        cmd_err;
  logic        beat_valid;
  logic        beat_ready;
  logic [3:0]  beat_id;
  logic [31:0] beat_addr;
  logic [4:0]  beat_offset;
  logic [7:0]  beat_idx;
  logic        beat_last;

  int checks   = 0;
  int failures = 0;

  logic [31:0] obs_addr[$];
  logic [4:0]  obs_off[$];
  logic [7:0]  obs_idx[$];
  logic        obs_last[$];
  logic [3:0]  obs_id[$];
  logic [31:0] exp_addr[$];
  int          hold_viol;
  bit          timed_out;

  always #5 clk = ~clk;

  axi_burst_addr_gen dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .cmd_err(cmd_err),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
    .beat_addr(beat_addr), .beat_offset(beat_offset), .beat_idx(beat_idx),
    .beat_last(beat_last)
  );

  // Reference legality rules, in plain byte arithmetic.
  function automatic bit model_illegal(logic [31:0] addr, int len, int size, int burst);
    longint unsigned a, bytes, al, last_b;
    a = addr;
    if (size > 5) return 1;
    if (burst == 3) return 1;
    bytes = longint'(1) << size;
    if (burst == 2) begin
      if (!(len inside {1, 3, 7, 15})) return 1;
      if (a % bytes != 0) return 1;
    end
    if (burst == 0 && len > 15) return 1;
    if (burst == 1) begin
      al     = a - a % bytes;
      last_b = al + longint'(len + 1) * bytes - 1;
      if (last_b / 4096 != a / 4096) return 1;
    end
    return 0;
  endfunction

  // Reference beat addresses: i-th address computed directly, not stepwise.
  task automatic model_beats(logic [31:0] addr, int len, int size, int burst);
    longint unsigned a, bytes, w, lo, x;
    logic [63:0] t;
    exp_addr.delete();
    a     = addr;
    bytes = longint'(1) << size;
    w     = longint'(len + 1) * bytes;
    lo    = a - a % w;
    for (int i = 0; i <= len; i++) begin
      if (burst == 0)      x = a;
      else if (burst == 1) x = (i == 0) ? a : (a - a % bytes) + longint'(i) * bytes;
      else                 x = lo + ((a - lo) + longint'(i) * bytes) % w;
      t = x;
      exp_addr.push_back(t[31:0]);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send_cmd(logic [3:0] id, logic [31:0] addr, int len, int size, int burst,
                          output bit ok);
    int n;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = len[7:0];
    cmd_size  = size[2:0];
    cmd_burst = burst[1:0];
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Consume beats until last; beat_ready held low stall_len cycles on beat stall_idx,
  // otherwise low with probability rand_pct percent. Records hold violations.
  task automatic collect(int stall_idx, int stall_len, int rand_pct, int max_cycles);
    int          stalled;
    bit          done, rdy, prev_stall;
    logic [49:0] snap, cur;
    obs_addr.delete(); obs_off.delete(); obs_idx.delete();
    obs_last.delete(); obs_id.delete();
    hold_viol = 0; timed_out = 0; stalled = 0; done = 0; prev_stall = 0; snap = '0;
    for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
      cur = {beat_id, beat_addr, beat_offset, beat_idx, beat_last};
      if (prev_stall && (!beat_valid || cur !== snap)) hold_viol++;
      if (beat_valid && int'(beat_idx) == stall_idx && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else begin
        rdy = ($urandom_range(99) >= rand_pct);
      end
      beat_ready = rdy;
      if (beat_valid && rdy) begin
        obs_addr.push_back(beat_addr); obs_off.push_back(beat_offset);
        obs_idx.push_back(beat_idx);   obs_last.push_back(beat_last);
        obs_id.push_back(beat_id);
        if (beat_last) done = 1;
      end
      prev_stall = beat_valid && !rdy;
      snap = cur;
      @(posedge clk); @(negedge clk);
    end
    beat_ready = 1'b0;
    if (!done) timed_out = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; beat_ready = 1'b0;
    cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || cmd_err !== 1'b0 || beat_valid !== 1'b0 || beat_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready=%b err=%b valid=%b last=%b want 1 0 0 0",
               cmd_ready, cmd_err, beat_valid, beat_last);
    end
    checks++;
    if (beat_addr !== 32'h0 || beat_offset !== 5'h0 || beat_idx !== 8'h0 || beat_id !== 4'h0) begin
      failures++;
      $display("FAIL reset_data addr=%h off=%h idx=%h id=%h want zeros",
               beat_addr, beat_offset, beat_idx, beat_id);
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_incr();
    bit ok;
    send_cmd(4'h3, 32'h1004, 3, 2, 1, ok);
    collect(-1, 0, 0, 40);
    exp_addr = '{32'h1004, 32'h1008, 32'h100C, 32'h1010};
    checks++;
    if (!ok || timed_out || obs_addr.size() != exp_addr.size()) begin
      failures++;
      $display("FAIL incr_count got=%0d want=%0d ok=%0b timeout=%0b", obs_addr.size(), exp_addr.size(), ok, timed_out);
    end
    foreach (obs_addr[i]) if (i < exp_addr.size()) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_idx[i] !== 8'(i) || obs_last[i] !== (i == exp_addr.size() - 1) ||
          obs_off[i] !== exp_addr[i][4:0] || obs_id[i] !== 4'h3) begin
        failures++;
        $display("FAIL incr_beat%0d addr=%h want %h idx=%0d last=%b off=%0d id=%0d",
                 i, obs_addr[i], exp_addr[i], obs_idx[i], obs_last[i], obs_off[i], obs_id[i]);
      end
    end
    checks++;
    if (cmd_ready !== 1'b1 || beat_valid !== 1'b0) begin
      failures++;
      $display("FAIL incr_bubble ready=%b valid=%b want 1 0", cmd_ready, beat_valid);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    send_cmd(4'h5, 32'h1038, 3, 3, 2, ok);
    collect(-1, 0, 0, 40);
    exp_addr = '{32'h1038, 32'h1020, 32'h1028, 32'h1030};
    checks++;
    if (!ok || timed_out || obs_addr.size() != exp_addr.size()) begin
      failures++;
      $display("FAIL wrap_count got=%0d want=%0d ok=%0b timeout=%0b", obs_addr.size(), exp_addr.size(), ok, timed_out);
    end
    foreach (obs_addr[i]) if (i < exp_addr.size()) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_idx[i] !== 8'(i) || obs_last[i] !== (i == exp_addr.size() - 1) ||
          obs_off[i] !== exp_addr[i][4:0] || obs_id[i] !== 4'h5) begin
        failures++;
        $display("FAIL wrap_beat%0d addr=%h want %h idx=%0d last=%b off=%0d id=%0d",
                 i, obs_addr[i], exp_addr[i], obs_idx[i], obs_last[i], obs_off[i], obs_id[i]);
      end
    end
  endtask

  task automatic test_fixed_unaligned();
    bit ok;
    send_cmd(4'h9, 32'h2000, 2, 5, 0, ok);
    collect(-1, 0, 0, 40);
    exp_addr = '{32'h2000, 32'h2000, 32'h2000};
    checks++;
    if (!ok || timed_out || obs_addr.size() != exp_addr.size()) begin
      failures++;
      $display("FAIL fixed_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end
    foreach (obs_addr[i]) if (i < exp_addr.size()) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_idx[i] !== 8'(i) || obs_last[i] !== (i == exp_addr.size() - 1) ||
          obs_off[i] !== 5'd0 || obs_id[i] !== 4'h9) begin
        failures++;
        $display("FAIL fixed_beat%0d addr=%h want %h idx=%0d last=%b off=%0d",
                 i, obs_addr[i], exp_addr[i], obs_idx[i], obs_last[i], obs_off[i]);
      end
    end
    send_cmd(4'hA, 32'h1003, 1, 2, 1, ok);
    collect(-1, 0, 0, 40);
    checks++;
    if (!ok || timed_out || obs_addr.size() != 2) begin
      failures++;
      $display("FAIL unaligned_count got=%0d want=2", obs_addr.size());
    end else begin
      checks++;
      if (obs_addr[0] !== 32'h1003 || obs_off[0] !== 5'd3 || obs_addr[1] !== 32'h1004 ||
          obs_off[1] !== 5'd4 || obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1) begin
        failures++;
        $display("FAIL unaligned_beats got %h/%0d %h/%0d want 00001003/3 00001004/4",
                 obs_addr[0], obs_off[0], obs_addr[1], obs_off[1]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] a_t[6] = '{32'h0, 32'h100, 32'h0FF0, 32'h40, 32'h800, 32'h1004};
    int          l_t[6] = '{0, 2, 1, 0, 16, 3};
    int          s_t[6] = '{6, 2, 4, 2, 2, 3};
    int          b_t[6] = '{1, 2, 1, 3, 0, 2};
    bit ok;
    for (int k = 0; k < 6; k++) begin
      send_cmd(4'h1, a_t[k], l_t[k], s_t[k], b_t[k], ok);
      checks++;
      if (!ok || cmd_err !== 1'b1 || beat_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL illegal%0d_pulse err=%b valid=%b ready=%b want 1 0 1", k, cmd_err, beat_valid, cmd_ready);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (cmd_err !== 1'b0 || beat_valid !== 1'b0) begin
        failures++;
        $display("FAIL illegal%0d_after err=%b valid=%b want 0 0", k, cmd_err, beat_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    send_cmd(4'h6, 32'h0, 7, 5, 1, ok);
    collect(2, 5, 0, 60);
    checks++;
    if (!ok || timed_out || obs_addr.size() != 8) begin
      failures++;
      $display("FAIL bp_count got=%0d want=8", obs_addr.size());
    end
    foreach (obs_addr[i]) begin
      checks++;
      if (obs_addr[i] !== 32'(i * 32) || obs_idx[i] !== 8'(i) || obs_last[i] !== (i == 7)) begin
        failures++;
        $display("FAIL bp_beat%0d addr=%h want %h idx=%0d last=%b", i, obs_addr[i], 32'(i * 32), obs_idx[i], obs_last[i]);
      end
    end
    checks++;
    if (hold_viol != 0) begin
      failures++;
      $display("FAIL bp_hold violations=%0d want 0", hold_viol);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    send_cmd(4'h7, 32'h5000, 15, 2, 1, ok);
    beat_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    beat_ready = 1'b0;
    checks++;
    if (!ok || beat_valid !== 1'b1 || beat_idx !== 8'd1 || beat_addr !== 32'h5004) begin
      failures++;
      $display("FAIL rst_mid_beat1 valid=%b idx=%0d addr=%h want 1 1 00005004", beat_valid, beat_idx, beat_addr);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (beat_valid !== 1'b0 || cmd_ready !== 1'b1 || beat_last !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state valid=%b ready=%b last=%b want 0 1 0", beat_valid, cmd_ready, beat_last);
    end
    reset = 1'b0;
    send_cmd(4'h2, 32'h3010, 1, 3, 2, ok);
    collect(-1, 0, 0, 40);
    checks++;
    if (!ok || timed_out || obs_addr.size() != 2) begin
      failures++;
      $display("FAIL rst_wrap_count got=%0d want=2", obs_addr.size());
    end else begin
      checks++;
      if (obs_addr[0] !== 32'h3010 || obs_addr[1] !== 32'h3018 || obs_last[1] !== 1'b1 || obs_last[0] !== 1'b0) begin
        failures++;
        $display("FAIL rst_wrap_beats got %h %h last=%b%b want 00003010 00003018 01",
                 obs_addr[0], obs_addr[1], obs_last[0], obs_last[1]);
      end
    end
  endtask

  // Second command held on cmd_valid throughout the first burst.
  task automatic test_back_to_back();
    bit ok;
    send_cmd(4'hB, 32'h4000, 3, 4, 1, ok);
    cmd_id = 4'hC; cmd_addr = 32'h6100; cmd_len = 8'd1; cmd_size = 3'd2; cmd_burst = 2'd0;
    cmd_valid = 1'b1;
    collect(-1, 0, 0, 40);
    checks++;
    if (!ok || timed_out || obs_addr.size() != 4 || obs_addr[3] !== 32'h4030 || obs_id[3] !== 4'hB) begin
      failures++;
      $display("FAIL b2b_first count=%0d want 4 (last addr 00004030 id b)", obs_addr.size());
    end
    checks++;
    if (cmd_ready !== 1'b1 || beat_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_bubble ready=%b valid=%b want 1 0", cmd_ready, beat_valid);
    end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    collect(-1, 0, 0, 40);
    checks++;
    if (timed_out || obs_addr.size() != 2 || obs_addr[0] !== 32'h6100 || obs_addr[1] !== 32'h6100 || obs_id[0] !== 4'hC) begin
      failures++;
      $display("FAIL b2b_second count=%0d want 2 beats at 00006100 id c", obs_addr.size());
    end
  endtask

  task automatic test_random();
    bit          ok, ill;
    logic [31:0] addr;
    logic [3:0]  id;
    int          len, size, burst;
    int          lens[5] = '{1, 2, 3, 7, 15};
    for (int n = 0; n < 60; n++) begin
      burst = $urandom_range(3);
      size  = $urandom_range(6);
      id    = 4'($urandom_range(15));
      addr  = $urandom;
      if (burst == 2) len = lens[$urandom_range(4)];
      else if ($urandom_range(7) == 0) len = $urandom_range(255);
      else len = $urandom_range(15);
      if (burst == 2 && size <= 5 && $urandom_range(3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      ill = model_illegal(addr, len, size, burst);
      send_cmd(id, addr, len, size, burst, ok);
      if (ill) begin
        checks++;
        if (!ok || cmd_err !== 1'b1 || beat_valid !== 1'b0) begin
          failures++;
          $display("FAIL rand%0d_err err=%b valid=%b want 1 0 (a=%h l=%0d s=%0d b=%0d)",
                   n, cmd_err, beat_valid, addr, len, size, burst);
        end
        @(posedge clk); @(negedge clk);
      end else begin
        model_beats(addr, len, size, burst);
        collect(-1, 0, 25, 2000);
        checks++;
        if (!ok || timed_out || obs_addr.size() != exp_addr.size() || hold_viol != 0 || cmd_err !== 1'b0) begin
          failures++;
          $display("FAIL rand%0d_count got=%0d want=%0d hold=%0d err=%b (a=%h l=%0d s=%0d b=%0d)",
                   n, obs_addr.size(), exp_addr.size(), hold_viol, cmd_err, addr, len, size, burst);
        end
        foreach (obs_addr[i]) if (i < exp_addr.size()) begin
          checks++;
          if (obs_addr[i] !== exp_addr[i] || obs_idx[i] !== 8'(i) || obs_last[i] !== (i == exp_addr.size() - 1) ||
              obs_off[i] !== exp_addr[i][4:0] || obs_id[i] !== id) begin
            failures++;
            $display("FAIL rand%0d_beat%0d addr=%h want %h idx=%0d last=%b off=%0d id=%0d",
                     n, i, obs_addr[i], exp_addr[i], obs_idx[i], obs_last[i], obs_off[i], obs_id[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_unaligned();
    test_illegal();
    test_backpressure();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
